// File: rtl/simple_tx.sv
// simple_tx: store-and-forward byte packet transmitter.
// Buffers one AXI-Stream-style packet, then sends it on a txd/txen/txer byte
// interface as SFD, TYPE, SIZE, PAYLOAD (padded to 8 bytes), FCS, followed by
// an inter-frame gap with txen low.
// Optional build macro: SIMPLE_TX_ERR_INJECT_EN adds err_inject_in. A packet
// whose tlast transfer sees err_inject_in high is sent with an inverted FCS
// byte, and txer_out is asserted for that one cycle.
module simple_tx #(
  parameter int G_MEM_SIZE = 256,
  parameter int G_IFG      = 12
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [7:0]  tdata_in,
  input  logic        tvalid_in,
  input  logic        tlast_in,
`ifdef SIMPLE_TX_ERR_INJECT_EN
  input  logic        err_inject_in,
`endif
  output logic        tready_out,
  output logic [7:0]  txd_out,
  output logic        txen_out,
  output logic        txer_out,
  output logic [15:0] stat_packet_sent_cnt,
  output logic [15:0] stat_packet_drop_cnt
);

  // The SIZE field is one byte, so the payload can never exceed 255 bytes.
  localparam int MAX_PAYLOAD = (G_MEM_SIZE < 255) ? G_MEM_SIZE : 255;
  localparam int AW          = (G_MEM_SIZE > 1) ? $clog2(G_MEM_SIZE) : 1;
  localparam int MIN_PAYLOAD = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_DISCARD,
    S_SFD,
    S_TYPE,
    S_SIZE,
    S_PAYLOAD,
    S_FCS,
    S_GAP
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  wptr_q, wptr_d;      // bytes stored for the current packet
  logic [15:0] cnt_q, cnt_d;        // position inside the current field / gap
  logic [7:0]  fcs_q, fcs_d;
  logic [7:0]  txd_q, txd_d;
  logic        txen_q, txen_d;
  logic        txer_q, txer_d;
  logic        tready_q, tready_d;
  logic [15:0] sent_q, sent_d;
  logic [15:0] drop_q, drop_d;
`ifdef SIMPLE_TX_ERR_INJECT_EN
  logic        err_q, err_d;
`endif

  logic [7:0]    mem [G_MEM_SIZE];
  logic [7:0]    rdata_q;
  logic [AW-1:0] rd_addr;
  logic          wr_en;
  logic          xfer;
  logic [8:0]    count_inc;
  logic [7:0]    size_w;

  assign xfer      = tvalid_in && tready_q;
  assign count_inc = {1'b0, wptr_q} + 9'd1;
  assign size_w    = (wptr_q < 8'(MIN_PAYLOAD)) ? 8'(MIN_PAYLOAD) : wptr_q;

  // Next-state, datapath and registered-output decode.
  // NOTE: every signal gets a default first so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    fcs_d   = fcs_q;
    txd_d   = 8'h00;
    txen_d  = 1'b0;
    txer_d  = 1'b0;
    sent_d  = sent_q;
    drop_d  = drop_q;
    wr_en   = 1'b0;
    rd_addr = '0;
`ifdef SIMPLE_TX_ERR_INJECT_EN
    err_d   = err_q;
`endif

    case (state_q)
      S_IDLE: state_d = S_LOAD;

      S_LOAD: begin
        if (xfer) begin
          wr_en = 1'b1;
          if (tlast_in) begin
            state_d = S_SFD;
            wptr_d  = count_inc[7:0];
            cnt_d   = '0;
`ifdef SIMPLE_TX_ERR_INJECT_EN
            err_d   = err_inject_in;
`endif
          end else if (count_inc == 9'(MAX_PAYLOAD)) begin
            // Buffer full and packet still going: it cannot be sent.
            state_d = S_DISCARD;
            wptr_d  = '0;
          end else begin
            wptr_d = count_inc[7:0];
          end
        end
      end

      S_DISCARD: begin
        if (xfer && tlast_in) begin
          drop_d  = drop_q + 16'd1;
          state_d = S_LOAD;
        end
      end

      S_SFD: begin
        txen_d = 1'b1;
        txd_d  = (cnt_q[1:0] == 2'd3) ? 8'h7F : 8'h55;
        fcs_d  = 8'h00;
        if (cnt_q[1:0] == 2'd3) begin
          state_d = S_TYPE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_TYPE: begin
        txen_d = 1'b1;
        txd_d  = cnt_q[0] ? 8'h34 : 8'h12;
        fcs_d  = fcs_q ^ txd_d;
        if (cnt_q[0]) begin
          state_d = S_SIZE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_SIZE: begin
        txen_d  = 1'b1;
        txd_d   = size_w;
        fcs_d   = fcs_q ^ txd_d;
        rd_addr = '0;               // prefetch payload byte 0
        state_d = S_PAYLOAD;
        cnt_d   = '0;
      end

      S_PAYLOAD: begin
        txen_d  = 1'b1;
        txd_d   = (cnt_q < {8'h00, wptr_q}) ? rdata_q : 8'h00;
        fcs_d   = fcs_q ^ txd_d;
        rd_addr = AW'(cnt_q + 16'd1);  // fetch the byte for the next cycle
        if (cnt_q == ({8'h00, size_w} - 16'd1)) begin
          state_d = S_FCS;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_FCS: begin
        txen_d  = 1'b1;
`ifdef SIMPLE_TX_ERR_INJECT_EN
        txd_d   = err_q ? ~fcs_q : fcs_q;
        txer_d  = err_q;
`else
        txd_d   = fcs_q;
`endif
        sent_d  = sent_q + 16'd1;
        state_d = S_GAP;
        cnt_d   = '0;
      end

      S_GAP: begin
        if (cnt_q == 16'(G_IFG - 1)) begin
          state_d = S_LOAD;
          wptr_d  = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    tready_d = (state_d == S_LOAD) || (state_d == S_DISCARD);
  end

  // State and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values computed above.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= S_IDLE;
      wptr_q   <= '0;
      cnt_q    <= '0;
      fcs_q    <= '0;
      txd_q    <= '0;
      txen_q   <= 1'b0;
      txer_q   <= 1'b0;
      tready_q <= 1'b0;
      sent_q   <= '0;
      drop_q   <= '0;
`ifdef SIMPLE_TX_ERR_INJECT_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      cnt_q    <= cnt_d;
      fcs_q    <= fcs_d;
      txd_q    <= txd_d;
      txen_q   <= txen_d;
      txer_q   <= txer_d;
      tready_q <= tready_d;
      sent_q   <= sent_d;
      drop_q   <= drop_d;
`ifdef SIMPLE_TX_ERR_INJECT_EN
      err_q    <= err_d;
`endif
    end
  end

  // Payload buffer with registered read port.
  // NOTE: the buffer is deliberately not reset; bytes are always written
  // before they are read, and a reset would prevent RAM inference.
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[AW'(wptr_q)] <= tdata_in;
    rdata_q <= mem[rd_addr];
  end

  assign tready_out           = tready_q;
  assign txd_out              = txd_q;
  assign txen_out             = txen_q;
  assign txer_out             = txer_q;
  assign stat_packet_sent_cnt = sent_q;
  assign stat_packet_drop_cnt = drop_q;

endmodule

// File: tb/tb_simple_tx.sv
// tb_simple_tx: directed self-checking bench for simple_tx.
module tb_simple_tx;

  localparam int G_MEM_SIZE = 256;
  localparam int G_IFG      = 12;
  localparam int LIMIT      = 2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  tdata = 8'h00;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
`ifdef SIMPLE_TX_ERR_INJECT_EN
  logic        err_inject = 1'b0;
`endif
  logic        tready;
  logic [7:0]  txd;
  logic        txen;
  logic        txer;
  logic [15:0] sent_cnt;
  logic [15:0] drop_cnt;

  simple_tx #(.G_MEM_SIZE(G_MEM_SIZE), .G_IFG(G_IFG)) dut (
    .clk_in               (clk),
    .rst_n_in             (rst_n),
    .tdata_in             (tdata),
    .tvalid_in            (tvalid),
    .tlast_in             (tlast),
`ifdef SIMPLE_TX_ERR_INJECT_EN
    .err_inject_in        (err_inject),
`endif
    .tready_out           (tready),
    .txd_out              (txd),
    .txen_out             (txen),
    .txer_out             (txer),
    .stat_packet_sent_cnt (sent_cnt),
    .stat_packet_drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int total  = 0;
  int passed = 0;

  int txen_cycles = 0;
  int txer_cycles = 0;
  always @(negedge clk) begin
    if (txen === 1'b1) txen_cycles++;
    if (txer === 1'b1) txer_cycles++;
  end

  logic [7:0] pay_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic       rxer_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] rx_at(input int i);
    return (i < rx_q.size()) ? rx_q[i] : 8'hxx;
  endfunction

  // Reference frame: SFD, TYPE, SIZE=max(n,8), zero-padded payload, XOR FCS.
  task automatic build_expected();
    int n;
    int s;
    logic [7:0] f;
    n = pay_q.size();
    s = (n < 8) ? 8 : n;
    exp_q = '{8'h55, 8'h55, 8'h55, 8'h7F, 8'h12, 8'h34};
    exp_q.push_back(8'(s));
    for (int i = 0; i < s; i++) exp_q.push_back((i < n) ? pay_q[i] : 8'h00);
    f = 8'h00;
    for (int i = 4; i < exp_q.size(); i++) f = f ^ exp_q[i];
    exp_q.push_back(f);
  endtask

  // Called on a negedge; returns on the negedge after the byte transferred.
  task automatic send_byte(input logic [7:0] d, input logic last, input logic inj);
    int t;
    t = 0;
    tdata  = d;
    tvalid = 1'b1;
    tlast  = last;
`ifdef SIMPLE_TX_ERR_INJECT_EN
    err_inject = inj & last;
`else
    if (inj) $display("note: error injection not built in");
`endif
    while (tready !== 1'b1 && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    if (t >= LIMIT) check("send_timeout", 1, 0);
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'b0;
`ifdef SIMPLE_TX_ERR_INJECT_EN
    err_inject = 1'b0;
`endif
  endtask

  task automatic send_packet(input int gap_max, input logic inj);
    for (int i = 0; i < pay_q.size(); i++) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      send_byte(pay_q[i], (i == pay_q.size() - 1), inj);
    end
  endtask

  // Collect one frame; counts cycles where tready was high inside the envelope.
  task automatic capture(output int ready_seen);
    int t;
    t = 0;
    ready_seen = 0;
    rx_q.delete();
    rxer_q.delete();
    while (txen !== 1'b1 && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    if (t >= LIMIT) check("frame_start_timeout", 1, 0);
    t = 0;
    while (txen === 1'b1 && t < 600) begin
      rx_q.push_back(txd);
      rxer_q.push_back(txer);
      if (tready === 1'b1) ready_seen++;
      @(negedge clk);
      t++;
    end
  endtask

  task automatic compare_frame(input string tag);
    int errs;
    errs = 0;
    check({tag, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (rx_at(i) !== exp_q[i]) errs++;
    check({tag, "_bytes"}, errs, 0);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (tready !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int rs;
    int n;
    int base;
    int exp_txer;
    exp_txer = 0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tready", tready, 0);
    check("rst_txd", txd, 8'h00);
    check("rst_txen", txen, 0);
    check("rst_txer", txer, 0);
    check("rst_sent", sent_cnt, 0);
    check("rst_drop", drop_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", tready, 1);

    // 10-byte payload 01..0A
    pay_q.delete();
    for (int i = 1; i <= 10; i++) pay_q.push_back(8'(i));
    build_expected();
    send_packet(0, 1'b0);
    check("ready_drops_after_tlast", tready, 0);
    capture(rs);
    compare_frame("p10");
    check("p10_size", rx_at(6), 8'h0A);
    check("p10_fcs", rx_at(17), 8'h27);
    check("p10_ready_in_frame", rs, 0);
    check("p10_sent", sent_cnt, 1);
    wait_ready(n);
    check("p10_gap_len", n, G_IFG - 1);

    // 3-byte payload, padded to 8
    pay_q = '{8'hAA, 8'hBB, 8'hCC};
    build_expected();
    send_packet(1, 1'b0);
    capture(rs);
    compare_frame("p3");
    check("p3_size", rx_at(6), 8'h08);
    check("p3_pad", rx_at(10), 8'h00);
    check("p3_fcs", rx_at(15), 8'hF3);
    wait_ready(n);
    check("p3_sent", sent_cnt, 2);

    // 300-byte oversize packet: discarded, nothing on the line
    base = txen_cycles;
    pay_q.delete();
    for (int i = 0; i < 300; i++) pay_q.push_back(8'(i));
    send_packet(0, 1'b0);
    repeat (20) @(negedge clk);
    check("drop_no_txen", txen_cycles - base, 0);
    check("drop_cnt", drop_cnt, 1);
    check("drop_sent_unchanged", sent_cnt, 2);
    check("drop_ready_back", tready, 1);

    // Valid packet right after the drop
    pay_q = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    build_expected();
    send_packet(0, 1'b0);
    capture(rs);
    compare_frame("after_drop");
    wait_ready(n);

    // Two back-to-back 8-byte packets with random tvalid gaps
    pay_q = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    build_expected();
    send_packet(3, 1'b0);
    capture(rs);
    compare_frame("b2b_a");
    check("b2b_a_ready_in_frame", rs, 0);
    pay_q = '{8'hFE, 8'hDC, 8'hBA, 8'h98, 8'h76, 8'h54, 8'h32, 8'h10};
    build_expected();
    send_packet(3, 1'b0);
    capture(rs);
    compare_frame("b2b_b");
    check("b2b_b_ready_in_frame", rs, 0);
    wait_ready(n);
    check("b2b_gap_len", n, G_IFG - 1);
    check("b2b_sent", sent_cnt, 5);

    // Reset during payload byte 5
    pay_q.delete();
    for (int i = 1; i <= 10; i++) pay_q.push_back(8'(i));
    send_packet(0, 1'b0);
    n = 0;
    while (txen !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    repeat (11) @(negedge clk);
    check("midrst_byte5", txd, 8'h05);
    rst_n = 1'b0;
    #1;
    check("midrst_txen", txen, 0);
    check("midrst_txd", txd, 8'h00);
    check("midrst_tready", tready, 0);
    check("midrst_sent", sent_cnt, 0);
    check("midrst_drop", drop_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pay_q = '{8'hAA, 8'hBB, 8'hCC};
    build_expected();
    send_packet(0, 1'b0);
    capture(rs);
    compare_frame("post_rst");
    check("post_rst_sent", sent_cnt, 1);
    wait_ready(n);

`ifdef SIMPLE_TX_ERR_INJECT_EN
    // Error injection on the 10-byte case
    base = txer_cycles;
    pay_q.delete();
    for (int i = 1; i <= 10; i++) pay_q.push_back(8'(i));
    build_expected();
    exp_q[17] = ~exp_q[17];
    send_packet(0, 1'b1);
    capture(rs);
    compare_frame("inj");
    check("inj_fcs", rx_at(17), 8'hD8);
    check("inj_txer_at_fcs", (rxer_q.size() == 18) ? rxer_q[17] : 1'bx, 1);
    repeat (2) @(negedge clk);
    check("inj_txer_cycles", txer_cycles - base, 1);
    check("inj_sent", sent_cnt, 2);
    exp_txer = 1;
    wait_ready(n);
`endif

    check("txer_total", txer_cycles, exp_txer);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
